// File: rtl/master_req_queue.sv
// master_req_queue: DEPTH-entry request FIFO that feeds master_port one transaction at a time.
// Define MRQ_STATS_EN to build the wr_count/rd_count completion counters.
module master_req_queue #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_mode,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] daddr,
  output logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dmode,
  output logic                  dvalid,
  input  logic                  dready,
  input  logic [DATA_WIDTH-1:0] drdata,
  output logic                  busy,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  mode;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  req_t                  mem_q [DEPTH];
  req_t                  mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  state_t                state_q, state_d;
  req_t                  dreq_q, dreq_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  push, pop;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign req_ready = (count_q != CNT_FULL);
  assign push      = req_valid & req_ready;
  assign pop       = (state_q == WAIT_DONE) & dready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{addr: req_addr, wdata: req_wdata, mode: req_mode};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dreq_d      = dreq_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = ISSUE;
          dreq_d  = mem_q[rd_ptr_q];
        end
      end
      ISSUE:     if (dready)  state_d = WAIT_BUSY;
      WAIT_BUSY: if (!dready) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (dready) begin
          state_d = IDLE;
          if (!dreq_q.mode) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = drdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      dreq_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      dreq_q      <= dreq_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign daddr     = dreq_q.addr;
  assign dwdata    = dreq_q.wdata;
  assign dmode     = dreq_q.mode;
  assign dvalid    = (state_q == ISSUE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (count_q != '0) | (state_q != IDLE);

`ifdef MRQ_STATS_EN
  logic [15:0] wr_count_q, wr_count_d;
  logic [15:0] rd_count_q, rd_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    if (pop) begin
      if (dreq_q.mode) wr_count_d = wr_count_q + 16'd1;
      else             rd_count_d = rd_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;
`else
  assign wr_count = '0;
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_master_req_queue.sv
// Bench for master_req_queue: behavioural master_port with random latency plus a queue-based
// reference model of the FIFO, issue order, read data and response timing.
module tb_master_req_queue;
  localparam int DEPTH = 4;
`ifdef MRQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_mode = 1'b0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] daddr;
  logic [7:0]  dwdata;
  logic        dmode;
  logic        dvalid;
  logic        dready;
  logic [7:0]  drdata = '0;
  logic        busy;
  logic [15:0] wr_count, rd_count;

  always #5 clk = ~clk;

  master_req_queue #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .daddr(daddr), .dwdata(dwdata), .dmode(dmode), .dvalid(dvalid),
    .dready(dready), .drdata(drdata),
    .busy(busy), .wr_count(wr_count), .rd_count(rd_count)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        mode;
    logic [7:0]  exp_rd;
  } ent_t;

  ent_t        pend[$];
  logic [24:0] act_iss[$], exp_iss[$];
  logic [39:0] act_rsp[$], exp_rsp[$];
  logic [7:0]  dev_mem [256];
  logic [7:0]  ref_mem [256];
  int          cyc = 0, model_cnt = 0, m_wr = 0, m_rd = 0;
  int          busy_cnt = 0, lat_lo = 1, lat_hi = 3;
  bit          dev_out = 1'b0, orphan = 1'b0, hold = 1'b0;
  logic        dev_rdy_q = 1'b1;
  logic [15:0] cur_addr = '0;
  logic        cur_mode = 1'b0;
  int          n_tests = 0, n_fail = 0;

  assign dready = dev_rdy_q & ~hold;

  // master_port stand-in plus reference model; the model never looks at DUT state.
  always @(posedge clk) begin : dev_model
    bit   pop, push;
    ent_t e;
    cyc <= cyc + 1;
    if (dready && dev_out) begin
      dev_out <= 1'b0;
      orphan  <= 1'b0;
    end
    if (dvalid === 1'b1 && dready) begin
      act_iss.push_back({daddr, dwdata, dmode});
      exp_iss.push_back(pend.size() != 0 ? {pend[0].addr, pend[0].wdata, pend[0].mode} : 25'h1FFFFFF);
      dev_out   <= 1'b1;
      dev_rdy_q <= 1'b0;
      busy_cnt  <= int'($urandom_range(lat_hi, lat_lo));
      cur_addr  <= daddr;
      cur_mode  <= dmode;
      if (dmode) dev_mem[daddr[7:0]] <= dwdata;
    end else if (!dev_rdy_q) begin
      if (busy_cnt <= 1) begin
        dev_rdy_q <= 1'b1;
        drdata    <= cur_mode ? 8'($urandom) : dev_mem[cur_addr[7:0]];
      end else begin
        busy_cnt <= busy_cnt - 1;
      end
    end
    if (rst) begin
      pend.delete();
      model_cnt <= 0;
      m_wr      <= 0;
      m_rd      <= 0;
      if (dev_out && !dready) orphan <= 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] <= dev_mem[i];
    end else begin
      pop  = dready && dev_out && !orphan && (pend.size() != 0);
      push = req_valid && (model_cnt < DEPTH);
      if (pop) begin
        e = pend.pop_front();
        if (e.mode) m_wr <= m_wr + 1;
        else begin
          m_rd <= m_rd + 1;
          exp_rsp.push_back({32'(cyc + 1), e.exp_rd});
        end
      end
      if (push) begin
        e.addr   = req_addr;
        e.wdata  = req_wdata;
        e.mode   = req_mode;
        e.exp_rd = ref_mem[req_addr[7:0]];
        if (req_mode) ref_mem[req_addr[7:0]] <= req_wdata;
        pend.push_back(e);
      end
      model_cnt <= model_cnt + int'(push) - int'(pop);
    end
  end

  always @(negedge clk) if (rsp_valid === 1'b1) act_rsp.push_back({32'(cyc), rsp_rdata});

  // Called at a negedge; holds req_valid until the model says the push was taken.
  task automatic push_req(input logic [15:0] a, input logic [7:0] d, input logic m);
    bit acc = 1'b0;
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_mode = m;
    for (int i = 0; i < 300 && !acc; i++) begin
      n_tests++;
      if (req_ready !== (model_cnt < DEPTH)) begin
        n_fail++;
        $display("FAIL push_ready: got %b want %b (addr %h)", req_ready, model_cnt < DEPTH, a);
      end
      acc = (model_cnt < DEPTH);
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_tests++;
    if (!acc) begin n_fail++; $display("FAIL push_timeout: addr %h never accepted", a); end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((model_cnt != 0 || dev_out || !dev_rdy_q) && n < 3000) begin
      n_tests++;
      if (busy !== (model_cnt != 0)) begin
        n_fail++;
        $display("FAIL %s busy: got %b want %b", name, busy, model_cnt != 0);
      end
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n >= 3000) begin n_fail++; $display("FAIL %s drain: timed out after %0d cycles", name, n); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
    n_tests++; if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset rsp_rdata: got %h want 00", rsp_rdata); end
    n_tests++; if (daddr !== 16'h0) begin n_fail++; $display("FAIL reset daddr: got %h want 0000", daddr); end
    n_tests++; if (dwdata !== 8'h00) begin n_fail++; $display("FAIL reset dwdata: got %h want 00", dwdata); end
    n_tests++; if (dmode !== 1'b0) begin n_fail++; $display("FAIL reset dmode: got %b want 0", dmode); end
    n_tests++; if (dvalid !== 1'b0) begin n_fail++; $display("FAIL reset dvalid: got %b want 0", dvalid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_tests++; if (wr_count !== 16'h0) begin n_fail++; $display("FAIL reset wr_count: got %h want 0", wr_count); end
    n_tests++; if (rd_count !== 16'h0) begin n_fail++; $display("FAIL reset rd_count: got %h want 0", rd_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write;
    int ni = act_iss.size(), nr = act_rsp.size();
    push_req(16'h1234, 8'hA5, 1'b1);
    n_tests++; if (dvalid !== 1'b0) begin n_fail++; $display("FAIL sw_dvalid_early: got %b want 0", dvalid); end
    @(negedge clk);
    n_tests++;
    if ({dvalid, daddr, dwdata, dmode} !== {1'b1, 16'h1234, 8'hA5, 1'b1}) begin
      n_fail++;
      $display("FAIL sw_issue: got v=%b a=%h d=%h m=%b want v=1 a=1234 d=a5 m=1", dvalid, daddr, dwdata, dmode);
    end
    wait_idle("single_write");
    n_tests++; if (act_iss.size() != ni + 1) begin n_fail++; $display("FAIL sw_iss_count: got %0d want %0d", act_iss.size(), ni + 1); end
    n_tests++; if (act_rsp.size() != nr) begin n_fail++; $display("FAIL sw_no_rsp: got %0d rsps want %0d", act_rsp.size(), nr); end
    n_tests++; if (dev_mem[8'h34] !== 8'hA5) begin n_fail++; $display("FAIL sw_mem: got %h want a5", dev_mem[8'h34]); end
  endtask

  task automatic test_write_read;
    int nr = act_rsp.size();
    push_req(16'h2010, 8'h3C, 1'b1);
    push_req(16'h2010, 8'h77, 1'b0);
    wait_idle("write_read");
    n_tests++;
    if (act_rsp.size() != nr + 1) begin
      n_fail++; $display("FAIL wr_rsp_count: got %0d want %0d", act_rsp.size(), nr + 1);
    end else begin
      n_tests++;
      if (act_rsp[nr][7:0] !== 8'h3C) begin n_fail++; $display("FAIL wr_rsp_data: got %h want 3c", act_rsp[nr][7:0]); end
    end
    n_tests++;
    if (act_iss.size() < 2 || act_iss[act_iss.size()-2] !== {16'h2010, 8'h3C, 1'b1} ||
        act_iss[act_iss.size()-1][24:9] !== 16'h2010 || act_iss[act_iss.size()-1][0] !== 1'b0) begin
      n_fail++; $display("FAIL wr_order: write/read to 2010 not issued in order");
    end
  endtask

  task automatic test_fill;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push_req(16'h5000 + 16'(i), 8'hB0 + 8'(i), 1'(i % 2 == 0));
    req_valid = 1'b1; req_addr = 16'h5004; req_wdata = 8'hB4; req_mode = 1'b0;
    repeat (3) begin
      n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b want 0", req_ready); end
      n_tests++; if (daddr !== 16'h5000 || dvalid !== 1'b1) begin n_fail++; $display("FAIL fill_hold_issue: got v=%b a=%h want v=1 a=5000", dvalid, daddr); end
      @(negedge clk);
    end
    hold = 1'b0;
    push_req(16'h5004, 8'hB4, 1'b0);
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL fill_refill_ready: got %b want 0", req_ready); end
    wait_idle("fill");
  endtask

  task automatic test_reset_mid;
    int n = 0;
    lat_lo = 6; lat_hi = 6;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push_req(16'h3000 + 16'(i * 17), 8'h50 + 8'(i), 1'b0);
    hold = 1'b0;
    while (!(dev_out && !dev_rdy_q) && n < 100) begin @(negedge clk); n++; end
    n_tests++; if (n >= 100) begin n_fail++; $display("FAIL rm_accept: no issue within %0d cycles", n); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_rdata, daddr, dwdata, dmode, dvalid, busy, wr_count, rd_count} !==
        {1'b1, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000}) begin
      n_fail++;
      $display("FAIL rm_outputs: got rdy=%b rv=%b rd=%h a=%h d=%h m=%b v=%b busy=%b wc=%h rc=%h want reset values",
               req_ready, rsp_valid, rsp_rdata, daddr, dwdata, dmode, dvalid, busy, wr_count, rd_count);
    end
    lat_lo = 1; lat_hi = 3;
    push_req(16'h3000, 8'h00, 1'b0);
    wait_idle("reset_mid");
  endtask

  task automatic test_random;
    logic [15:0] a;
    logic [7:0]  d;
    logic        m;
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 60; i++) begin
      a = 16'h4000 | (16'($urandom_range(0, 3)) << 8) | 16'($urandom_range(0, 15));
      d = 8'($urandom);
      m = 1'($urandom_range(0, 1));
      push_req(a, d, m);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle("random");
    n_tests++; if (wr_count !== (STATS ? 16'(m_wr) : 16'h0)) begin n_fail++; $display("FAIL rnd_wr_count: got %0d want %0d", wr_count, STATS ? m_wr : 0); end
    n_tests++; if (rd_count !== (STATS ? 16'(m_rd) : 16'h0)) begin n_fail++; $display("FAIL rnd_rd_count: got %0d want %0d", rd_count, STATS ? m_rd : 0); end
  endtask

  task automatic test_stats;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push_req(16'h6001, 8'h11, 1'b1);
    push_req(16'h6002, 8'h22, 1'b1);
    push_req(16'h6001, 8'h00, 1'b0);
    push_req(16'h6003, 8'h33, 1'b1);
    push_req(16'h6002, 8'h00, 1'b0);
    wait_idle("stats");
    n_tests++; if (wr_count !== (STATS ? 16'd3 : 16'd0)) begin n_fail++; $display("FAIL stats_wr: got %0d want %0d", wr_count, STATS ? 3 : 0); end
    n_tests++; if (rd_count !== (STATS ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL stats_rd: got %0d want %0d", rd_count, STATS ? 2 : 0); end
  endtask

  task automatic test_scoreboard;
    n_tests++;
    if (act_iss.size() != exp_iss.size()) begin
      n_fail++; $display("FAIL sb_iss_count: got %0d want %0d", act_iss.size(), exp_iss.size());
    end
    for (int i = 0; i < act_iss.size() && i < exp_iss.size(); i++) begin
      n_tests++;
      if (act_iss[i] !== exp_iss[i]) begin n_fail++; $display("FAIL sb_issue[%0d]: got %h want %h", i, act_iss[i], exp_iss[i]); end
    end
    n_tests++;
    if (act_rsp.size() != exp_rsp.size()) begin
      n_fail++; $display("FAIL sb_rsp_count: got %0d want %0d", act_rsp.size(), exp_rsp.size());
    end
    for (int i = 0; i < act_rsp.size() && i < exp_rsp.size(); i++) begin
      n_tests++;
      if (act_rsp[i] !== exp_rsp[i]) begin
        n_fail++;
        $display("FAIL sb_rsp[%0d]: got cyc %0d data %h want cyc %0d data %h", i,
                 act_rsp[i][39:8], act_rsp[i][7:0], exp_rsp[i][39:8], exp_rsp[i][7:0]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    test_reset();
    test_single_write();
    test_write_read();
    test_fill();
    test_reset_mid();
    test_random();
    test_stats();
    test_scoreboard();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
